swin_ctrl: RTL and testbench

SWIN_CTRL -- requirements
Module: swin_ctrl

---
 rtl/swin_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_swin_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swin_ctrl.sv
// swin_ctrl -- sequencing controller for a sliding-window pixel datapath.
//
// One frame runs in four phases:
//   LOAD  : accepts 2**CONF_ADDR_WIDTH configuration words and writes them
//           into the configuration BRAM, one write the cycle after each accept.
//   RUN   : accepts frame_beats*frame_lines 128-bit pixel beats and forwards
//           each one to the window datapath with a latency of one cycle.
//   FLUSH : waits FLUSH_CYCLES cycles so the datapath can drain.
//   DONE  : pulses done for one cycle, then the block returns to IDLE.
// abort (or rst_n low) returns to IDLE on the next edge. Any handshake
// offered in that cycle is dropped.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start, abort            frame start (sampled in IDLE only), abort to IDLE
//   frame_beats/lines       frame size, latched when start is accepted
//   conf_in_*               configuration word stream (valid/ready)
//   pix_in*                 pixel beat stream (valid/ready)
//   pix_data_out,
//   data_in_vld_out         registered pixel beat toward the datapath
//   conf_bram_wr_*          configuration BRAM write port
//   win_vld_in, win_cnt     window-valid from datapath, saturating count
//   busy, done, err         status: not idle, end-of-frame pulse, zero size
module swin_ctrl #(
  parameter int CONF_DATA_WIDTH = 19,
  parameter int CONF_ADDR_WIDTH = 4,
  parameter int FLUSH_CYCLES    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [7:0]                 frame_beats,
  input  logic [10:0]                frame_lines,
  input  logic [CONF_DATA_WIDTH-1:0] conf_in_data,
  input  logic                       conf_in_vld,
  output logic                       conf_in_rdy,
  input  logic [127:0]               pix_in,
  input  logic                       pix_in_vld,
  output logic                       pix_in_rdy,
  output logic [127:0]               pix_data_out,
  output logic                       data_in_vld_out,
  output logic [CONF_ADDR_WIDTH-1:0] conf_bram_wr_addr,
  output logic [CONF_DATA_WIDTH-1:0] conf_bram_wr_data,
  output logic                       conf_bram_wr_en,
  input  logic                       win_vld_in,
  output logic [15:0]                win_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0]         FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [CONF_ADDR_WIDTH-1:0] CONF_LAST  = '1;

  state_t                      state_q, state_d;
  logic [7:0]                  beats_q, beats_d;
  logic [10:0]                 lines_q, lines_d;
  logic [7:0]                  beat_q, beat_d;
  logic [10:0]                 line_q, line_d;
  logic [CONF_ADDR_WIDTH-1:0]  conf_addr_q, conf_addr_d;
  logic [FLUSH_W-1:0]          flush_q, flush_d;
  logic [15:0]                 win_cnt_q, win_cnt_d;
  logic                        err_q, err_d;
  logic                        wr_en_q, wr_en_d;
  logic [CONF_ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [CONF_DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                        dvld_q, dvld_d;
  logic [127:0]                pix_data_q, pix_data_d;

  logic conf_hs;
  logic pix_hs;

  // Ready and status depend only on the state register, so they never
  // combinationally depend on the valid inputs.
  assign conf_in_rdy = (state_q == S_LOAD);
  assign pix_in_rdy  = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

  assign conf_hs = conf_in_rdy & conf_in_vld;
  assign pix_hs  = pix_in_rdy & pix_in_vld;

  assign err               = err_q;
  assign win_cnt           = win_cnt_q;
  assign conf_bram_wr_en   = wr_en_q;
  assign conf_bram_wr_addr = wr_addr_q;
  assign conf_bram_wr_data = wr_data_q;
  assign data_in_vld_out   = dvld_q;
  assign pix_data_out      = pix_data_q;

  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    lines_d     = lines_q;
    beat_d      = beat_q;
    line_d      = line_q;
    conf_addr_d = conf_addr_q;
    flush_d     = flush_q;
    win_cnt_d   = win_cnt_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    dvld_d      = 1'b0;
    pix_data_d  = pix_data_q;

    // Window counting is independent of the phase sequencing; it runs in
    // every busy cycle, including the cycle in which abort is seen.
    if (busy && win_vld_in && (win_cnt_q != 16'hFFFF)) begin
      win_cnt_d = win_cnt_q + 16'd1;
    end

    if (abort) begin
      // Handshakes in this cycle are dropped: no write, no pixel forward.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            beats_d     = frame_beats;
            lines_d     = frame_lines;
            beat_d      = '0;
            line_d      = '0;
            conf_addr_d = '0;
            win_cnt_d   = '0;
            err_d       = 1'b0;
            if ((frame_beats == 8'd0) || (frame_lines == 11'd0)) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (conf_hs) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = conf_addr_q;
            wr_data_d   = conf_in_data;
            conf_addr_d = conf_addr_q + 1'b1;
            if (conf_addr_q == CONF_LAST) begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (pix_hs) begin
            dvld_d     = 1'b1;
            pix_data_d = pix_in;
            if (beat_q == (beats_q - 8'd1)) begin
              beat_d = '0;
              if (line_q == (lines_q - 11'd1)) begin
                line_d  = '0;
                flush_d = '0;
                state_d = S_FLUSH;
              end else begin
                line_d = line_q + 11'd1;
              end
            end else begin
              beat_d = beat_q + 8'd1;
            end
          end
        end
        S_FLUSH: begin
          if (flush_q == FLUSH_LAST) begin
            state_d = S_DONE;
          end else begin
            flush_d = flush_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beats_q     <= '0;
      lines_q     <= '0;
      beat_q      <= '0;
      line_q      <= '0;
      conf_addr_q <= '0;
      flush_q     <= '0;
      win_cnt_q   <= '0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      dvld_q      <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      lines_q     <= lines_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      conf_addr_q <= conf_addr_d;
      flush_q     <= flush_d;
      win_cnt_q   <= win_cnt_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      dvld_q      <= dvld_d;
      pix_data_q  <= pix_data_d;
    end
  end

endmodule

// File: tb/tb_swin_ctrl.sv
// tb_swin_ctrl -- self-checking bench for swin_ctrl.
// A frame-level reference model (phase name, words accepted, total beats
// accepted against beats*lines, flush cycles remaining) predicts every output
// each cycle; a compare process checks the DUT on the falling edge. Directed
// scenarios add hand-computed literal checks that pin the model.
module tb_swin_ctrl;
  localparam int DW = 19;
  localparam int AW = 4;
  localparam int FC = 4;
  localparam int NCONF = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [7:0]     frame_beats = '0;
  logic [10:0]    frame_lines = '0;
  logic [DW-1:0]  conf_in_data = '0;
  logic           conf_in_vld = 1'b0;
  logic           conf_in_rdy;
  logic [127:0]   pix_in = '0;
  logic           pix_in_vld = 1'b0;
  logic           pix_in_rdy;
  logic [127:0]   pix_data_out;
  logic           data_in_vld_out;
  logic [AW-1:0]  conf_bram_wr_addr;
  logic [DW-1:0]  conf_bram_wr_data;
  logic           conf_bram_wr_en;
  logic           win_vld_in = 1'b0;
  logic [15:0]    win_cnt;
  logic           busy;
  logic           done;
  logic           err;

  swin_ctrl #(.CONF_DATA_WIDTH(DW), .CONF_ADDR_WIDTH(AW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_beats(frame_beats), .frame_lines(frame_lines),
    .conf_in_data(conf_in_data), .conf_in_vld(conf_in_vld), .conf_in_rdy(conf_in_rdy),
    .pix_in(pix_in), .pix_in_vld(pix_in_vld), .pix_in_rdy(pix_in_rdy),
    .pix_data_out(pix_data_out), .data_in_vld_out(data_in_vld_out),
    .conf_bram_wr_addr(conf_bram_wr_addr), .conf_bram_wr_data(conf_bram_wr_data),
    .conf_bram_wr_en(conf_bram_wr_en), .win_vld_in(win_vld_in), .win_cnt(win_cnt),
    .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_FLUSH, M_DONE} mode_t;
  mode_t          m_mode = M_IDLE;
  int             m_beats, m_lines, m_conf, m_pix, m_flush, m_win;
  bit             m_err;
  bit             m_live = 1'b0;
  bit             e_wr_en, e_dvld;
  int             e_wr_addr;
  logic [DW-1:0]  e_wr_data;
  logic [127:0]   e_pix;
  bit             m_busy;

  always @(posedge clk) begin
    cyc_n++;
    if (!rst_n) begin
      m_live = 1'b1;
      m_mode = M_IDLE;
      m_beats = 0; m_lines = 0; m_conf = 0; m_pix = 0; m_flush = 0; m_win = 0;
      m_err = 1'b0;
      e_wr_en = 1'b0; e_dvld = 1'b0; e_wr_addr = 0; e_wr_data = '0; e_pix = '0;
    end else if (m_live) begin
      m_busy = (m_mode != M_IDLE);
      e_wr_en = 1'b0;
      e_dvld  = 1'b0;
      if (m_busy && win_vld_in && m_win < 65535) m_win++;
      if (abort) begin
        m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: if (start) begin
            m_beats = int'(frame_beats);
            m_lines = int'(frame_lines);
            m_conf = 0; m_pix = 0; m_win = 0; m_err = 1'b0;
            if (m_beats * m_lines == 0) begin
              m_err = 1'b1;
              m_mode = M_DONE;
            end else begin
              m_mode = M_LOAD;
            end
          end
          M_LOAD: if (conf_in_vld) begin
            e_wr_en = 1'b1;
            e_wr_addr = m_conf;
            e_wr_data = conf_in_data;
            m_conf++;
            if (m_conf == NCONF) m_mode = M_RUN;
          end
          M_RUN: if (pix_in_vld) begin
            e_dvld = 1'b1;
            e_pix = pix_in;
            m_pix++;
            if (m_pix == m_beats * m_lines) begin
              m_mode = M_FLUSH;
              m_flush = FC;
            end
          end
          M_FLUSH: begin
            m_flush--;
            if (m_flush == 0) m_mode = M_DONE;
          end
          M_DONE: m_mode = M_IDLE;
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      chk("conf_in_rdy", 128'(conf_in_rdy), 128'(m_mode == M_LOAD));
      chk("pix_in_rdy", 128'(pix_in_rdy), 128'(m_mode == M_RUN));
      chk("busy", 128'(busy), 128'(m_mode != M_IDLE));
      chk("done", 128'(done), 128'(m_mode == M_DONE));
      chk("err", 128'(err), 128'(m_err));
      chk("win_cnt", 128'(win_cnt), 128'(m_win));
      chk("wr_en", 128'(conf_bram_wr_en), 128'(e_wr_en));
      chk("wr_addr", 128'(conf_bram_wr_addr), 128'(e_wr_addr));
      chk("wr_data", 128'(conf_bram_wr_data), 128'(e_wr_data));
      chk("data_vld", 128'(data_in_vld_out), 128'(e_dvld));
      chk("pix_data", pix_data_out, e_pix);
    end
  end

  // ---------------- event monitor for literal checks ----------------
  int n_wr, n_dvld, n_done, n_addr_ne_data, last_dvld_cyc, done_cyc;
  always @(negedge clk) begin
    if (conf_bram_wr_en === 1'b1) begin
      n_wr++;
      if (int'(conf_bram_wr_data) != int'(conf_bram_wr_addr)) n_addr_ne_data++;
    end
    if (data_in_vld_out === 1'b1) begin
      n_dvld++;
      last_dvld_cyc = cyc_n;
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc_n;
    end
  end

  task automatic clr_mon();
    n_wr = 0; n_dvld = 0; n_done = 0; n_addr_ne_data = 0;
    last_dvld_cyc = 0; done_cyc = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    start = 1'b0; abort = 1'b0; conf_in_vld = 1'b0; pix_in_vld = 1'b0;
  endtask

  // Runs one frame from IDLE until the block is idle again.
  // seq: config word k carries value k; tog: pix valid toggles each cycle.
  task automatic run_frame(input int b, input int l, input int cpct, input int ppct,
                           input bit seq, input bit tog, input bit noise,
                           input bit winr, input bit ab);
    int k = 0;
    int budget = 0;
    bit t = 1'b0;
    bit hs;
    frame_beats = 8'(b);
    frame_lines = 11'(l);
    start = 1'b1;
    cyc();
    start = 1'b0;
    while (busy && budget < 5000) begin
      conf_in_vld = ($urandom_range(99) < cpct);
      conf_in_data = seq ? DW'(k) : DW'($urandom);
      if (tog) begin
        pix_in_vld = t;
        t = ~t;
      end else begin
        pix_in_vld = ($urandom_range(99) < ppct);
      end
      pix_in = {$urandom, $urandom, $urandom, $urandom};
      win_vld_in = winr ? 1'($urandom_range(1)) : 1'b0;
      abort = ab && ($urandom_range(149) == 0);
      if (noise) begin
        start = ($urandom_range(3) == 0);
        frame_beats = 8'($urandom_range(255));
        frame_lines = 11'($urandom_range(2047));
      end
      hs = conf_in_rdy && conf_in_vld;
      cyc();
      if (hs) k++;
      budget++;
    end
    quiet();
    win_vld_in = 1'b0;
    chk("frame_finished", 128'(busy), 128'(0));
    if (busy) begin
      abort = 1'b1;
      cyc();
      abort = 1'b0;
    end
  endtask

  task automatic feed_confs();
    int k = 0;
    int budget = 0;
    while (k < NCONF && budget < 200) begin
      conf_in_vld = 1'b1;
      conf_in_data = DW'($urandom);
      if (conf_in_rdy) k++;
      cyc();
      budget++;
    end
    conf_in_vld = 1'b0;
  endtask

  task automatic feed_pix(input int n);
    int k = 0;
    int budget = 0;
    while (k < n && budget < 200) begin
      pix_in_vld = 1'b1;
      pix_in = {$urandom, $urandom, $urandom, $urandom};
      if (pix_in_rdy) k++;
      cyc();
      budget++;
    end
    pix_in_vld = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    clr_mon();
    repeat (3) cyc();
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_win_cnt", 128'(win_cnt), 128'(0));
    chk("reset_pix_data", pix_data_out, 128'(0));
    chk("reset_conf_rdy", 128'(conf_in_rdy), 128'(0));
    rst_n = 1'b1;
    cyc();

    // Basic frame: 2x2, config words equal to their index.
    clr_mon();
    run_frame(2, 2, 100, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("basic frame: writes=%0d beats=%0d done=%0d", n_wr, n_dvld, n_done);
    chk("basic_writes", 128'(n_wr), 128'(16));
    chk("basic_addr_eq_data", 128'(n_addr_ne_data), 128'(0));
    chk("basic_beats", 128'(n_dvld), 128'(4));
    chk("basic_done", 128'(n_done), 128'(1));
    chk("basic_done_delay", 128'(done_cyc - last_dvld_cyc), 128'(FC));
    chk("basic_err", 128'(err), 128'(0));

    // Backpressure: pixel valid toggles every cycle, 3 beats x 2 lines.
    clr_mon();
    run_frame(3, 2, 100, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("backpressure frame: beats=%0d done=%0d", n_dvld, n_done);
    chk("bp_beats", 128'(n_dvld), 128'(6));
    chk("bp_done", 128'(n_done), 128'(1));

    // Zero size.
    clr_mon();
    frame_beats = 8'd0;
    frame_lines = 11'd5;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("zero_done", 128'(done), 128'(1));
    chk("zero_err", 128'(err), 128'(1));
    chk("zero_busy", 128'(busy), 128'(1));
    cyc();
    chk("zero_done_off", 128'(done), 128'(0));
    chk("zero_idle", 128'(busy), 128'(0));
    chk("zero_err_sticky", 128'(err), 128'(1));
    chk("zero_writes", 128'(n_wr), 128'(0));
    $display("zero-size frame: err=%0b writes=%0d", err, n_wr);

    // Abort during RUN after 3 beats, with a handshake in the abort cycle.
    clr_mon();
    frame_beats = 8'd2;
    frame_lines = 11'd3;
    start = 1'b1;
    cyc();
    start = 1'b0;
    feed_confs();
    feed_pix(3);
    pix_in_vld = 1'b1;
    pix_in = {4{32'hDEADBEEF}};
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    pix_in_vld = 1'b0;
    chk("abort_idle", 128'(busy), 128'(0));
    chk("abort_no_fwd", 128'(data_in_vld_out), 128'(0));
    chk("abort_pix_rdy", 128'(pix_in_rdy), 128'(0));
    repeat (3) cyc();
    chk("abort_beats", 128'(n_dvld), 128'(3));
    chk("abort_no_done", 128'(n_done), 128'(0));
    $display("abort frame: beats forwarded=%0d done=%0d", n_dvld, n_done);
    clr_mon();
    run_frame(2, 3, 100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("after_abort_beats", 128'(n_dvld), 128'(6));
    chk("after_abort_done", 128'(n_done), 128'(1));

    // Start pulses with other sizes during LOAD and RUN must be ignored.
    clr_mon();
    run_frame(3, 2, 70, 60, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    $display("ignored-start frame: beats=%0d done=%0d", n_dvld, n_done);
    chk("ign_start_beats", 128'(n_dvld), 128'(6));
    chk("ign_start_done", 128'(n_done), 128'(1));

    // Reset in the middle of LOAD.
    frame_beats = 8'd2;
    frame_lines = 11'd2;
    start = 1'b1;
    abort = 1'b1;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    conf_in_vld = 1'b1;
    repeat (5) cyc();
    win_vld_in = 1'b1;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    conf_in_vld = 1'b0;
    win_vld_in = 1'b0;
    chk("midreset_idle", 128'(busy), 128'(0));
    chk("midreset_wr_en", 128'(conf_bram_wr_en), 128'(0));
    chk("midreset_win", 128'(win_cnt), 128'(0));
    $display("mid-frame reset: busy=%0b", busy);
    cyc();

    // Randomized frames, some with random aborts and zero sizes.
    for (int f = 0; f < 24; f++) begin
      int b, l;
      b = $urandom_range(5);
      l = $urandom_range(4);
      if (f < 4) begin
        b = (b == 0) ? 1 : b;
        l = (l == 0) ? 1 : l;
      end
      clr_mon();
      run_frame(b, l, $urandom_range(30, 100), $urandom_range(30, 100), 1'b0, 1'b0,
                1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)));
      $display("random frame %0d: beats=%0d lines=%0d forwarded=%0d done=%0d err=%0b",
               f, b, l, n_dvld, n_done, err);
      repeat ($urandom_range(3)) cyc();
    end

    // Window count saturation over a long frame.
    frame_beats = 8'd1;
    frame_lines = 11'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    win_vld_in = 1'b1;
    repeat (70000) cyc();
    feed_confs();
    feed_pix(1);
    begin
      int budget = 0;
      while (busy && budget < 50) begin
        cyc();
        budget++;
      end
    end
    chk("sat_idle", 128'(busy), 128'(0));
    chk("sat_win_cnt", 128'(win_cnt), 128'(16'hFFFF));
    repeat (5) cyc();
    chk("sat_win_hold", 128'(win_cnt), 128'(16'hFFFF));
    $display("window count frame: win_cnt=%0h", win_cnt);
    win_vld_in = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
